// File: rtl/tp_col_serializer_if.sv
// Vector-in / element-out bundle between the transpose-memory reader and the scalar datapath.
interface tp_col_serializer_if #(
  parameter int BW    = 12,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [8*BW-1:0] i_data;
  logic            i_en;
  logic [BW-1:0]   o_data;
  logic            o_valid;
  logic            i_ready;
  logic [2:0]      o_idx;
  logic            o_last;
  logic [AW:0]     o_level;
  logic            o_overflow;

  modport master (
    output i_data, i_en, i_ready,
    input  o_data, o_valid, o_idx, o_last, o_level, o_overflow
  );

  modport slave (
    input  i_data, i_en, i_ready,
    output o_data, o_valid, o_idx, o_last, o_level, o_overflow
  );
endinterface

// File: rtl/tp_col_serializer.sv
// Buffers strobed 8-element vectors in a small FIFO and replays them one element per cycle
// on a valid/ready stream, element 0 (the most significant slice) first.
module tp_col_serializer #(
  parameter int BW    = 12,
  parameter int DEPTH = 8
) (
  input  logic               i_clk,
  input  logic               i_Reset,
  tp_col_serializer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic {EMPTY, STREAM} state_t;

  state_t          state;
  logic [8*BW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic [8*BW-1:0] stage;
  logic [8*BW-1:0] head;
  logic [2:0]      idx;
  logic [BW-1:0]   data_q;
  logic            last_q;
  logic            overflow;
  logic            fifo_empty;
  logic            fifo_full;
  logic            xfer;
  logic            pop;
  logic            push;

  function automatic logic [BW-1:0] elem(input logic [8*BW-1:0] vec, input logic [2:0] i);
    return vec[(7 - int'(i)) * BW +: BW];
  endfunction

  // A pop refills the output stage either from idle or right after its last element leaves,
  // so a full FIFO can still accept a write on that same edge.
  always_comb begin
    fifo_empty = (level == '0);
    fifo_full  = (level == FULL_LEVEL);
    head       = mem[rd_ptr];
    xfer       = (state == STREAM) && bus.i_ready;
    pop        = !fifo_empty && ((state == EMPTY) || (xfer && idx == 3'd7));
    push       = bus.i_en && (!fifo_full || pop);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= bus.i_data;
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state    <= EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      stage    <= '0;
      idx      <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      if (bus.i_en && !push) overflow <= 1'b1;

      case (state)
        EMPTY: begin
          if (pop) begin
            state  <= STREAM;
            stage  <= head;
            idx    <= 3'd0;
            data_q <= elem(head, 3'd0);
            last_q <= 1'b0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (idx != 3'd7) begin
              idx    <= idx + 3'd1;
              data_q <= elem(stage, idx + 3'd1);
              last_q <= (idx == 3'd6);
            end else if (pop) begin
              stage  <= head;
              idx    <= 3'd0;
              data_q <= elem(head, 3'd0);
              last_q <= 1'b0;
            end else begin
              state  <= EMPTY;
              stage  <= '0;
              idx    <= 3'd0;
              data_q <= '0;
              last_q <= 1'b0;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.o_valid    = (state == STREAM);
  assign bus.o_data     = data_q;
  assign bus.o_idx      = idx;
  assign bus.o_last     = last_q;
  assign bus.o_level    = level;
  assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_tp_col_serializer.sv
// Directed and random stimulus for tp_col_serializer, checked every cycle against a
// queue-of-vectors reference plus a transfer scoreboard.
module tb_tp_col_serializer;
  localparam int BW    = 12;
  localparam int DEPTH = 8;
  localparam int VW    = 8*BW;

  logic i_clk   = 1'b0;
  logic i_Reset = 1'b0;
  always #5 i_clk = ~i_clk;

  tp_col_serializer_if #(.BW(BW), .DEPTH(DEPTH)) bus ();

  tp_col_serializer #(.BW(BW), .DEPTH(DEPTH)) dut (
    .i_clk  (i_clk),
    .i_Reset(i_Reset),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a bounded queue of whole vectors, and the vector currently being emitted
  logic [VW-1:0] mq[$];
  logic [VW-1:0] mStage = '0;
  bit            mHave  = 1'b0;
  int            mIdx   = 0;
  bit            mOvf   = 1'b0;

  logic [BW-1:0] seenData[$];
  bit            seenLast[$];
  logic [BW-1:0] expQ[$];
  int            validCycles = 0;
  int            maxLevel    = 0;

  function automatic logic [BW-1:0] elemOf(input logic [VW-1:0] v, input int e);
    return v[(7-e)*BW +: BW];
  endfunction

  function automatic logic [VW-1:0] mkVec(input int base);
    logic [VW-1:0] v;
    v = '0;
    for (int e = 0; e < 8; e++) v[(7-e)*BW +: BW] = BW'(base + e + 1);
    return v;
  endfunction

  function automatic logic [VW-1:0] randVec();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit en, input logic [VW-1:0] data, input bit ready);
    bus.i_en    = en;
    bus.i_data  = data;
    bus.i_ready = ready;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clearLog();
    seenData.delete();
    seenLast.delete();
    expQ.delete();
    validCycles = 0;
    maxLevel    = 0;
  endtask

  task automatic pushExp(input logic [VW-1:0] v);
    for (int e = 0; e < 8; e++) expQ.push_back(elemOf(v, e));
  endtask

  task automatic compareSeen(input string name);
    checkOutput({name, "_count"}, VW'(seenData.size()), VW'(expQ.size()));
    for (int i = 0; i < seenData.size() && i < expQ.size(); i++)
      checkOutput({name, "_elem"}, VW'(seenData[i]), VW'(expQ[i]));
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((bus.o_valid || bus.o_level != 0) && n < budget) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_idle", VW'(bus.o_valid || bus.o_level != 0), '0);
  endtask

  // Reference update: the queue pops before it pushes so a write into a full FIFO
  // succeeds only when the output stage takes a vector on the same edge.
  initial begin
    forever begin
      @(posedge i_clk or negedge i_Reset);
      if (!i_Reset) begin
        mq.delete();
        mHave  = 1'b0;
        mIdx   = 0;
        mStage = '0;
        mOvf   = 1'b0;
      end else begin : upd
        bit xfer, pop, full;
        full = (mq.size() == DEPTH);
        xfer = mHave && bus.i_ready;
        pop  = (mq.size() > 0) && (!mHave || (xfer && mIdx == 7));
        if (xfer && mIdx < 7) mIdx++;
        else if (xfer && !pop) begin
          mHave = 1'b0;
          mIdx  = 0;
        end
        if (pop) begin
          mStage = mq.pop_front();
          mHave  = 1'b1;
          mIdx   = 0;
        end
        if (bus.i_en) begin
          if (!full || pop) mq.push_back(bus.i_data);
          else mOvf = 1'b1;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    if (i_Reset) begin
      checkOutput("valid",    VW'(bus.o_valid),    VW'(mHave));
      checkOutput("data",     VW'(bus.o_data),     mHave ? VW'(elemOf(mStage, mIdx)) : '0);
      checkOutput("idx",      VW'(bus.o_idx),      mHave ? VW'(mIdx) : '0);
      checkOutput("last",     VW'(bus.o_last),     VW'(mHave && mIdx == 7));
      checkOutput("level",    VW'(bus.o_level),    VW'(mq.size()));
      checkOutput("overflow", VW'(bus.o_overflow), VW'(mOvf));
      if (bus.o_valid) validCycles++;
      if (int'(bus.o_level) > maxLevel) maxLevel = int'(bus.o_level);
      if (bus.o_valid && bus.i_ready) begin
        seenData.push_back(bus.o_data);
        seenLast.push_back(bus.o_last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [VW-1:0] v;
    int n;
    bus.i_en    = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_valid",    VW'(bus.o_valid),    '0);
    checkOutput("rst_data",     VW'(bus.o_data),     '0);
    checkOutput("rst_idx",      VW'(bus.o_idx),      '0);
    checkOutput("rst_last",     VW'(bus.o_last),     '0);
    checkOutput("rst_level",    VW'(bus.o_level),    '0);
    checkOutput("rst_overflow", VW'(bus.o_overflow), '0);
    i_Reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);

    // Single vector with ready held high
    clearLog();
    v = mkVec(0);
    pushExp(v);
    applyStimulus(1'b1, v, 1'b1);
    checkOutput("t1_valid_at_strobe", VW'(bus.o_valid), '0);
    checkOutput("t1_level_at_strobe", VW'(bus.o_level), VW'(1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_valid_next", VW'(bus.o_valid), VW'(1));
    checkOutput("t1_first_elem", VW'(bus.o_data),  VW'(12'h001));
    checkOutput("t1_first_idx",  VW'(bus.o_idx),   '0);
    waitIdle(40);
    compareSeen("t1");
    if (seenLast.size() == 8) begin
      for (int i = 0; i < 8; i++) checkOutput("t1_last_flag", VW'(seenLast[i]), VW'(i == 7));
      checkOutput("t1_elem_last_literal", VW'(seenData[7]), VW'(12'h008));
    end
    checkOutput("t1_level_end", VW'(bus.o_level), '0);

    // Same vector with ready alternating, first valid cycle stalled
    clearLog();
    pushExp(v);
    applyStimulus(1'b1, v, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, bit'(i % 2));
    waitIdle(40);
    compareSeen("t2");
    checkOutput("t2_valid_cycles", VW'(validCycles), VW'(16));

    // Eight back-to-back vectors drained without a gap
    clearLog();
    for (int i = 0; i < 8; i++) begin
      v = randVec();
      pushExp(v);
      applyStimulus(1'b1, v, 1'b1);
    end
    waitIdle(120);
    compareSeen("t3");
    checkOutput("t3_valid_cycles", VW'(validCycles),    VW'(64));
    checkOutput("t3_peak_level",   VW'(maxLevel),       VW'(7));
    checkOutput("t3_overflow",     VW'(bus.o_overflow), '0);

    // Ten vectors against a stalled sink: the tenth is dropped
    clearLog();
    for (int i = 0; i < 10; i++) begin
      v = randVec();
      if (i < 9) pushExp(v);
      applyStimulus(1'b1, v, 1'b0);
    end
    checkOutput("t4_level_full", VW'(bus.o_level),    VW'(8));
    checkOutput("t4_overflow",   VW'(bus.o_overflow), VW'(1));
    checkOutput("t4_valid",      VW'(bus.o_valid),    VW'(1));
    waitIdle(200);
    compareSeen("t4");
    checkOutput("t4_count_literal",  VW'(seenData.size()), VW'(72));
    checkOutput("t4_overflow_stays", VW'(bus.o_overflow),  VW'(1));

    // Asynchronous reset mid-vector, then a fresh vector
    clearLog();
    applyStimulus(1'b1, randVec(), 1'b1);
    applyStimulus(1'b1, randVec(), 1'b1);
    n = 0;
    while (bus.o_idx != 3'd3 && n < 20) begin
      applyStimulus(1'b0, '0, 1'b1);
      n++;
    end
    checkOutput("t6_reached_idx3", VW'(bus.o_idx), VW'(3));
    #3;
    i_Reset = 1'b0;
    #1;
    checkOutput("t6_valid",    VW'(bus.o_valid),    '0);
    checkOutput("t6_data",     VW'(bus.o_data),     '0);
    checkOutput("t6_idx",      VW'(bus.o_idx),      '0);
    checkOutput("t6_level",    VW'(bus.o_level),    '0);
    checkOutput("t6_overflow", VW'(bus.o_overflow), '0);
    #1;
    i_Reset = 1'b1;
    clearLog();
    v = mkVec(12'hA00);
    pushExp(v);
    applyStimulus(1'b1, v, 1'b1);
    waitIdle(40);
    compareSeen("t6");
    if (seenData.size() == 8) begin
      checkOutput("t6_first_literal", VW'(seenData[0]), VW'(12'hA01));
      checkOutput("t6_last_literal",  VW'(seenData[7]), VW'(12'hA08));
    end

    // Full FIFO accepts a write on the edge the output stage pops
    clearLog();
    for (int i = 0; i < 9; i++) begin
      v = randVec();
      pushExp(v);
      applyStimulus(1'b1, v, 1'b0);
    end
    checkOutput("t5_level_full", VW'(bus.o_level), VW'(8));
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t5_idx7", VW'(bus.o_idx), VW'(7));
    v = randVec();
    pushExp(v);
    applyStimulus(1'b1, v, 1'b1);
    checkOutput("t5_level_kept", VW'(bus.o_level),    VW'(8));
    checkOutput("t5_overflow",   VW'(bus.o_overflow), '0);
    checkOutput("t5_idx_restart", VW'(bus.o_idx),     '0);
    waitIdle(200);
    compareSeen("t5");

    // Random traffic, alternating light and heavy strobe rates
    for (int seg = 0; seg < 12; seg++) begin
      for (int c = 0; c < 200; c++)
        applyStimulus(bit'($urandom_range(0, 99) < ((seg % 2) ? 25 : 6)), randVec(),
                      bit'($urandom_range(0, 3) != 0));
    end
    waitIdle(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
